// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD arithmetic datapath blocks.
// Contents: digit width and radix constants, the serial-unit FSM state type,
// the single-digit type and a digit validity helper.
package bcd_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned BCD_RADIX = 10;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic {
    StIdle,
    StRun
  } bcd_state_t;

  // True when the nibble is a legal decimal digit (0..9).
  function automatic logic is_bcd_digit(input bcd_digit_t dig);
    return dig < bcd_digit_t'(BCD_RADIX);
  endfunction

endpackage

// File: rtl/bcd_serial_subtractor_digit_sub.sv
// bcd_digit_sub: combinational single-digit BCD subtractor, d = a - b - bin.
// Ports:
//   a, b  : digit operands (4 bits)
//   bin   : borrow in
//   d     : result digit (4 bits), ten's-complement corrected on borrow
//   bout  : borrow out
// Digits above 9 are not rejected; the same arithmetic is applied and the
// result is truncated to 4 bits.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       bin,
  output bcd_digit_t d,
  output logic       bout
);

  // 5-bit two's-complement difference; bit 4 is the sign. Range -16..15 fits.
  logic [DIGIT_W:0] diff_raw;

  always_comb begin
    diff_raw = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bin};
    bout     = diff_raw[DIGIT_W];
    if (diff_raw[DIGIT_W]) begin
      d = diff_raw[DIGIT_W-1:0] + bcd_digit_t'(BCD_RADIX);
    end else begin
      d = diff_raw[DIGIT_W-1:0];
    end
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: digit-serial packed-BCD subtractor, Diff = A - B - Bin.
// One digit per clock, least significant first, start/busy/done handshake.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : request, sampled only while idle
//   A, B     : packed BCD minuend / subtrahend, digit 0 in [3:0]
//   Bin      : borrow in
//   busy     : operation in progress
//   done     : one-cycle pulse, Diff/Bout valid from this cycle on
//   Diff     : packed BCD difference (ten's complement when negative)
//   Bout     : borrow out, 1 when A < B + Bin
//   err      : (BCD_SUB_INPUT_CHECK_EN only) latched operand held a digit > 9
// Optional feature macro: BCD_SUB_INPUT_CHECK_EN.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  Bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   Diff,
`ifdef BCD_SUB_INPUT_CHECK_EN
  output logic                  Bout,
  output logic                  err
`else
  output logic                  Bout
`endif
);

  localparam int unsigned W    = DIGIT_W * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  bcd_state_t      state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            borrow_q, borrow_d;
  logic            bout_q, bout_d;
  logic            done_q, done_d;
  logic [IdxW-1:0] idx_q, idx_d;

  bcd_digit_t        dig;
  logic              dig_bout;
  logic [W+DIGIT_W-1:0] res_ext;
  logic [W-1:0]      res_shift;
  logic              last_digit;

  bcd_digit_sub u_digit_sub (
    .a    (a_q[DIGIT_W-1:0]),
    .b    (b_q[DIGIT_W-1:0]),
    .bin  (borrow_q),
    .d    (dig),
    .bout (dig_bout)
  );

  // New digits enter at the top and shift down, so after DIGITS steps the
  // first digit computed sits in position 0. Widened to stay legal at DIGITS=1.
  assign res_ext    = {dig, res_q};
  assign res_shift  = res_ext[W+DIGIT_W-1:DIGIT_W];
  assign last_digit = (idx_q == IdxW'(DIGITS - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          res_d    = '0;
          idx_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        a_d      = a_q >> DIGIT_W;
        b_d      = b_q >> DIGIT_W;
        borrow_d = dig_bout;
        res_d    = res_shift;
        idx_d    = idx_q + 1'b1;
        if (last_digit) begin
          // Result is exposed only here, never mid-operation.
          diff_d  = res_shift;
          bout_d  = dig_bout;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
      idx_q    <= idx_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;

`ifdef BCD_SUB_INPUT_CHECK_EN
  // Validity is judged on the operands at load time, because the operand
  // registers are consumed by shifting during the run.
  logic in_bad;
  logic bad_q;
  logic err_q;

  always_comb begin
    in_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(A[i*DIGIT_W +: DIGIT_W]) || !is_bcd_digit(B[i*DIGIT_W +: DIGIT_W])) begin
        in_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StIdle && start) begin
        bad_q <= in_bad;
      end
      if (state_q == StRun && last_digit) begin
        err_q <= bad_q;
      end
    end
  end

  assign err = err_q;
`endif

endmodule
